// File: rtl/sobel_window_gen_if.sv
// Pixel stream in, 3x3 window out, for the Sobel front end.
// The source drives the master side; the window generator is the slave.
interface sobel_window_gen_if;
   logic [7:0] pix_in;
   logic       pix_valid;
   logic       sof;
   logic [7:0] z1;
   logic [7:0] z2;
   logic [7:0] z3;
   logic [7:0] z4;
   logic [7:0] z5;
   logic [7:0] z6;
   logic [7:0] z7;
   logic [7:0] z8;
   logic [7:0] z9;
   logic       win_valid;
   logic       frame_done;

   modport master (
      output pix_in, pix_valid, sof,
      input  z1, z2, z3, z4, z5, z6, z7, z8, z9,
      input  win_valid, frame_done
   );

   modport slave (
      input  pix_in, pix_valid, sof,
      output z1, z2, z3, z4, z5, z6, z7, z8, z9,
      output win_valid, frame_done
   );
endinterface

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3 window generator: two line buffers plus a shifting window.
// Emits only fully interior windows, one register stage after the pixel.
module sobel_window_gen #(
   parameter int COLS = 576,
   parameter int ROWS = 436
) (
   input logic              clk,
   input logic              reset,
   sobel_window_gen_if.slave bus
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   typedef logic [CW-1:0] col_t;
   typedef logic [RW-1:0] row_t;

   localparam col_t LAST_COL = col_t'(COLS - 1);
   localparam row_t LAST_ROW = row_t'(ROWS - 1);

   col_t       r_col;
   row_t       r_row;
   logic [7:0] r_lb0 [COLS];
   logic [7:0] r_lb1 [COLS];
   logic [7:0] r_win [9];
   logic       r_win_valid;
   logic       r_frame_done;

   logic       w_acc;
   logic       w_sof;
   col_t       w_col;
   row_t       w_row;
   logic       w_col_last;
   logic       w_row_last;
   col_t       w_col_nxt;
   row_t       w_row_nxt;
   logic [7:0] w_lb0_q;
   logic [7:0] w_lb1_q;
   logic       w_qual;
   logic       w_done;

   assign w_acc = bus.pix_valid;
   assign w_sof = bus.sof & bus.pix_valid;

   // sof overrides the counters so a short or long frame recovers here
   assign w_col = w_sof ? '0 : r_col;
   assign w_row = w_sof ? '0 : r_row;

   assign w_col_last = (w_col == LAST_COL);
   assign w_row_last = (w_row == LAST_ROW);

   always_comb begin
      w_col_nxt = w_col + col_t'(1);
      w_row_nxt = w_row;
      if (w_col_last) begin
         w_col_nxt = '0;
         w_row_nxt = w_row_last ? '0 : w_row + row_t'(1);
      end
   end

   assign w_lb0_q = r_lb0[w_col];
   assign w_lb1_q = r_lb1[w_col];

   assign w_qual = !w_sof
                && (w_row >= row_t'(2))
                && (w_col >= col_t'(2));
   assign w_done = w_qual && w_row_last && w_col_last;

   // Line buffers carry no reset; rows 0/1 refill them before first use
   always_ff @(posedge clk) begin
      if (w_acc && reset) begin
         r_lb1[w_col] <= w_lb0_q;
         r_lb0[w_col] <= bus.pix_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win        <= '{default: '0};
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_win_valid  <= w_acc & w_qual;
         r_frame_done <= w_acc & w_done;
         if (w_acc) begin
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb1_q;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb0_q;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= bus.pix_in;
         end
      end
   end

   assign bus.z1         = r_win[0];
   assign bus.z2         = r_win[1];
   assign bus.z3         = r_win[2];
   assign bus.z4         = r_win[3];
   assign bus.z5         = r_win[4];
   assign bus.z6         = r_win[5];
   assign bus.z7         = r_win[6];
   assign bus.z8         = r_win[7];
   assign bus.z9         = r_win[8];
   assign bus.win_valid  = r_win_valid;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image.
// Pixel value is {row, col} plus a per-frame offset.
module tb_sobel_window_gen;
   localparam int C  = 5;
   localparam int R  = 4;
   localparam int NW = (R - 2) * (C - 2);

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   sobel_window_gen_if bus_if ();

   sobel_window_gen #(
      .COLS (C),
      .ROWS (R)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [72:0] q_win [$];
   wire  [71:0] w_z = {bus_if.z1, bus_if.z2, bus_if.z3,
                       bus_if.z4, bus_if.z5, bus_if.z6,
                       bus_if.z7, bus_if.z8, bus_if.z9};

   always @(negedge clk) begin
      if (bus_if.win_valid === 1'b1)
         q_win.push_back({bus_if.frame_done, w_z});
   end

   function automatic logic [7:0] pv(input logic [7:0] off,
                                     input int r, input int c);
      return off + 8'(r * 16 + c);
   endfunction

   // {frame_done, z1..z9} for the k-th interior window of a clean frame
   function automatic logic [72:0] exp_win(input logic [7:0] off,
                                           input int k);
      logic [72:0] v;
      int r, c;
      r = 2 + k / (C - 2);
      c = 2 + k % (C - 2);
      v[72] = (k % NW) == NW - 1;
      for (int i = 0; i < 9; i++)
         v[71 - 8*i -: 8] = pv(off, r - 2 + i / 3, c - 2 + i % 3);
      return v;
   endfunction

   task automatic px(input logic [7:0] p, input logic s);
      bus_if.pix_in    = p;
      bus_if.sof       = s;
      bus_if.pix_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.pix_valid = 1'b0;
      bus_if.sof       = 1'b0;
   endtask

   task automatic bub();
      bus_if.pix_valid = 1'b0;
      bus_if.sof       = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset            = 1'b0;
      bus_if.pix_valid = 1'b1;
      bus_if.pix_in    = 8'h55;
      bus_if.sof       = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if ({w_z, bus_if.win_valid, bus_if.frame_done} !== 74'd0) begin
            n_err++;
            $display("FAIL reset[%0d]: got z=%h wv=%b fd=%b want 0",
                     i, w_z, bus_if.win_valid, bus_if.frame_done);
         end
      end
      n_cmp++;
      if (q_win.size() != 0) begin
         n_err++;
         $display("FAIL reset_pulses: got %0d want 0", q_win.size());
      end
      bus_if.pix_valid = 1'b0;
      bus_if.sof       = 1'b0;
      reset            = 1'b1;
      bub();
   endtask

   task automatic test_first_window();
      logic [72:0] e;
      logic        ev;
      q_win.delete();
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            px(pv(8'h00, r, c), r == 0 && c == 0);
            ev = (r >= 2) && (c >= 2);
            n_cmp++;
            if (bus_if.win_valid !== ev) begin
               n_err++;
               $display("FAIL first_wv(%0d,%0d): got %b want %b",
                        r, c, bus_if.win_valid, ev);
            end
            if (r == 2 && c == 2) begin
               e = exp_win(8'h00, 0);
               n_cmp++;
               if (w_z !== e[71:0]) begin
                  n_err++;
                  $display("FAIL first_z: got %h want %h", w_z, e[71:0]);
               end
            end
         end
      end
      bub();
      n_cmp++;
      if (q_win.size() != NW) begin
         n_err++;
         $display("FAIL first_count: got %0d want %0d", q_win.size(), NW);
      end
      for (int k = 0; k < q_win.size() && k < NW; k++) begin
         e = exp_win(8'h00, k);
         n_cmp++;
         if (q_win[k] !== e) begin
            n_err++;
            $display("FAIL first_win[%0d]: got %h want %h", k, q_win[k], e);
         end
      end
   endtask

   task automatic test_stalls();
      logic [72:0] e;
      logic [71:0] hold;
      int nb;
      q_win.delete();
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            nb = 0;
            while ($urandom_range(99) < 40 && nb < 8) begin
               hold = w_z;
               bub();
               n_cmp++;
               if ({w_z, bus_if.win_valid, bus_if.frame_done}
                   !== {hold, 2'b00}) begin
                  n_err++;
                  $display("FAIL stall_hold(%0d,%0d): got %h/%b want %h/0",
                           r, c, w_z, bus_if.win_valid, hold);
               end
               nb++;
            end
            px(pv(8'h00, r, c), r == 0 && c == 0);
         end
      end
      bub();
      n_cmp++;
      if (q_win.size() != NW) begin
         n_err++;
         $display("FAIL stall_count: got %0d want %0d", q_win.size(), NW);
      end
      for (int k = 0; k < q_win.size() && k < NW; k++) begin
         e = exp_win(8'h00, k);
         n_cmp++;
         if (q_win[k] !== e) begin
            n_err++;
            $display("FAIL stall_win[%0d]: got %h want %h", k, q_win[k], e);
         end
      end
   endtask

   task automatic test_row_boundary();
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            px(pv(8'h00, r, c), r == 0 && c == 0);
            if (r == 3 && c < 2) begin
               n_cmp++;
               if (bus_if.win_valid !== 1'b0) begin
                  n_err++;
                  $display("FAIL row_gap(%0d,%0d): got wv=%b want 0",
                           r, c, bus_if.win_valid);
               end
            end
            if (r == 3 && c == 2) begin
               n_cmp++;
               if ({bus_if.win_valid, bus_if.z5} !== {1'b1, 8'h21}) begin
                  n_err++;
                  $display("FAIL row_next: got wv=%b z5=%h want 1/21",
                           bus_if.win_valid, bus_if.z5);
               end
            end
            if (c == C - 1 && r >= 2) begin
               n_cmp++;
               if (bus_if.frame_done !== (r == R - 1)) begin
                  n_err++;
                  $display("FAIL row_fd(%0d): got %b want %b",
                           r, bus_if.frame_done, r == R - 1);
               end
            end
         end
      end
      bub();
   endtask

   task automatic test_back_to_back();
      logic [72:0] e;
      logic [7:0]  off;
      q_win.delete();
      for (int f = 0; f < 2; f++) begin
         off = (f == 0) ? 8'h00 : 8'h80;
         for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
               px(pv(off, r, c), r == 0 && c == 0);
      end
      bub();
      n_cmp++;
      if (q_win.size() != 2 * NW) begin
         n_err++;
         $display("FAIL b2b_count: got %0d want %0d", q_win.size(), 2 * NW);
      end
      if (q_win.size() > NW) begin
         n_cmp++;
         if (q_win[NW][71:64] !== 8'h80) begin
            n_err++;
            $display("FAIL b2b_z1: got %h want 80", q_win[NW][71:64]);
         end
      end
      for (int k = 0; k < q_win.size() && k < 2 * NW; k++) begin
         e = exp_win((k < NW) ? 8'h00 : 8'h80, k % NW);
         n_cmp++;
         if (q_win[k] !== e) begin
            n_err++;
            $display("FAIL b2b_win[%0d]: got %h want %h", k, q_win[k], e);
         end
      end
   endtask

   task automatic test_abort_resync();
      logic [72:0] e;
      // partial frame cut at (2,1) by a fresh sof
      q_win.delete();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < C; c++)
            px(pv(8'h40, r, c), r == 0 && c == 0);
      px(pv(8'h40, 2, 0), 1'b0);
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            px(pv(8'h00, r, c), r == 0 && c == 0);
      bub();
      n_cmp++;
      if (q_win.size() != NW) begin
         n_err++;
         $display("FAIL abort_count: got %0d want %0d", q_win.size(), NW);
      end
      for (int k = 0; k < q_win.size() && k < NW; k++) begin
         e = exp_win(8'h00, k);
         n_cmp++;
         if (q_win[k] !== e) begin
            n_err++;
            $display("FAIL abort_win[%0d]: got %h want %h", k, q_win[k], e);
         end
      end

      // sof landing on a qualifying position (3,3)
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            if (r < 3 || c < 3)
               px(pv(8'h40, r, c), r == 0 && c == 0);
      px(pv(8'h00, 0, 0), 1'b1);
      n_cmp++;
      if (bus_if.win_valid !== 1'b0) begin
         n_err++;
         $display("FAIL sof_qual: got wv=%b want 0", bus_if.win_valid);
      end
      q_win.delete();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            if (r != 0 || c != 0)
               px(pv(8'h00, r, c), 1'b0);
      bub();
      n_cmp++;
      if (q_win.size() != NW) begin
         n_err++;
         $display("FAIL sof_count: got %0d want %0d", q_win.size(), NW);
      end
      for (int k = 0; k < q_win.size() && k < NW; k++) begin
         e = exp_win(8'h00, k);
         n_cmp++;
         if (q_win[k] !== e) begin
            n_err++;
            $display("FAIL sof_win[%0d]: got %h want %h", k, q_win[k], e);
         end
      end

      // reset mid-row, then a frame with no sof at all
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            if (r < 3 || c < 2)
               px(pv(8'h40, r, c), r == 0 && c == 0);
      reset = 1'b0;
      #2;
      n_cmp++;
      if ({w_z, bus_if.win_valid, bus_if.frame_done} !== 74'd0) begin
         n_err++;
         $display("FAIL mid_reset: got z=%h wv=%b fd=%b want 0",
                  w_z, bus_if.win_valid, bus_if.frame_done);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      bub();
      q_win.delete();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            px(pv(8'h00, r, c), 1'b0);
      bub();
      n_cmp++;
      if (q_win.size() != NW) begin
         n_err++;
         $display("FAIL post_reset_count: got %0d want %0d",
                  q_win.size(), NW);
      end
      for (int k = 0; k < q_win.size() && k < NW; k++) begin
         e = exp_win(8'h00, k);
         n_cmp++;
         if (q_win[k] !== e) begin
            n_err++;
            $display("FAIL post_reset_win[%0d]: got %h want %h",
                     k, q_win[k], e);
         end
      end
   endtask

   initial begin
      bus_if.pix_in    = 8'h00;
      bus_if.pix_valid = 1'b0;
      bus_if.sof       = 1'b0;
      test_reset();
      test_first_window();
      test_stalls();
      test_row_boundary();
      test_back_to_back();
      test_abort_resync();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
